// File: rtl/jt12_interpol_ctrl.sv
// Clock-enable scheduler and 2-entry sample FIFO feeding the JT12 CIC interpolator.
// cen_out comes from a phase accumulator; cen_in marks every rate-th cen_out and pops a sample.
module jt12_interpol_ctrl #(
  parameter int inw  = 16,
  parameter int accw = 16,
  parameter int rate = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [accw-1:0]       step,
  input  logic                  clr_flags,
  input  logic signed [inw-1:0] snd_in,
  input  logic                  snd_in_valid,
  output logic                  snd_in_ready,
  output logic signed [inw-1:0] snd_out,
  output logic                  cen_in,
  output logic                  cen_out,
  output logic [1:0]            fifo_lvl,
  output logic                  underrun
);

  localparam int unsigned CNTW = (rate > 1) ? $clog2(rate) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(rate - 1);

  logic [accw-1:0]       acc;
  logic [accw:0]         sum;
  logic                  carry;
  logic [CNTW-1:0]       out_cnt;
  logic signed [inw-1:0] mem0, mem1;
  logic [1:0]            level;
  logic                  pop, push;

  assign sum          = {1'b0, acc} + {1'b0, step};
  assign carry        = sum[accw];
  assign pop          = en & carry & (out_cnt == '0);
  assign snd_in_ready = (level < 2'd2);
  assign push         = snd_in_valid & snd_in_ready;
  assign fifo_lvl     = level;

  // Phase accumulator and strobe generation; en=0 holds phase and drops strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      out_cnt <= '0;
      cen_out <= 1'b0;
      cen_in  <= 1'b0;
    end else if (en) begin
      acc     <= sum[accw-1:0];
      cen_out <= carry;
      cen_in  <= pop;
      if (carry) out_cnt <= (out_cnt == CNT_LAST) ? '0 : out_cnt + CNTW'(1);
    end else begin
      cen_out <= 1'b0;
      cen_in  <= 1'b0;
    end
  end

  // Shift-style FIFO: mem0 is always the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0    <= '0;
      mem1    <= '0;
      level   <= 2'd0;
      snd_out <= '0;
    end else if (pop) begin
      if (level != 2'd0) snd_out <= mem0;
      case (level)
        2'd0: if (push) begin
          mem0  <= snd_in;
          level <= 2'd1;
        end
        2'd1: if (push) mem0 <= snd_in;
              else      level <= 2'd0;
        default: begin
          mem0  <= mem1;
          level <= 2'd1;
        end
      endcase
    end else if (push) begin
      if (level == 2'd0) mem0 <= snd_in;
      else               mem1 <= snd_in;
      level <= level + 2'd1;
    end
  end

  // Sticky underrun; a new empty pop overrides a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        underrun <= 1'b0;
    else if (pop && level == 2'd0)  underrun <= 1'b1;
    else if (clr_flags)             underrun <= 1'b0;
  end

endmodule
